// File: rtl/prio_enc_pipe.sv
// prio_enc_pipe: registered N-input priority encoder with a pending-request
// store and a valid/ready output port.
//
// Request pulses are merged into a pending vector and emitted one index per
// accepted transfer, highest priority first. Nothing is lost while the
// output is stalled.
//
// Build option: define PRIO_ENC_RR_EN for round-robin priority. Leave it
// undefined for fixed MSB-first priority. Ports and reset values are the
// same in both builds.
//
// Handshake: out_idx is transferred on a rising clk edge where out_valid
// and out_ready are both high. While out_valid is high and out_ready is
// low, out_idx and out_valid hold. out_valid never depends combinationally
// on out_ready.
module prio_enc_pipe #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         collide,
  output logic         busy
);

  logic [N-1:0] pend;
  logic [N-1:0] req_en;
  logic [N-1:0] cand_vec;
  logic [N-1:0] sel_onehot;
  logic [W-1:0] sel;
  logic         sel_found;
  logic         load;

  // Candidates are everything pending plus this cycle's enabled requests.
  always_comb begin
    req_en     = en ? req : '0;
    cand_vec   = pend | req_en;
    load       = (!out_valid || out_ready) && (cand_vec != '0);
    sel_onehot = N'(1) << sel;
  end

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0] ptr;
  logic [W-1:0] probe;

  // Round-robin search: start at ptr and descend, wrapping from 0 to N-1.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    probe     = '0;
    for (int i = 0; i < N; i++) begin
      probe = W'((int'(ptr) + N - i) % N);
      if (!sel_found && cand_vec[probe]) begin
        sel       = probe;
        sel_found = 1'b1;
      end
    end
  end

  // The granted index becomes the lowest priority for the next search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= W'(N - 1);
    end else if (load) begin
      ptr <= (sel == '0) ? W'(N - 1) : sel - 1'b1;
    end
  end
`else
  // Fixed priority: an ascending scan lets the highest set index win.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand_vec[i]) begin
        sel       = W'(i);
        sel_found = 1'b1;
      end
    end
  end
`endif

  // Pending store: the selected bit is cleared when it moves into the
  // output register, so a request captured in its own grant cycle is
  // granted exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else if (load) begin
      pend <= cand_vec & ~sel_onehot;
    end else begin
      pend <= cand_vec;
    end
  end

  // Output register: load a new index, drop valid once drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_idx   <= sel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Collision flag: a request landed on a bit that was already pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collide <= 1'b0;
    end else begin
      collide <= |(req_en & pend);
    end
  end

  // Busy while anything is pending or still waiting at the output.
  always_comb begin
    busy = (|pend) || out_valid;
  end

  // sel_found only qualifies the search; load already covers the empty case.
  logic unused_found;
  always_comb begin
    unused_found = sel_found;
  end

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Directed testbench for prio_enc_pipe (N=8). Expected values are
// hand-computed. The priority-mode section follows PRIO_ENC_RR_EN.
module tb_prio_enc_pipe;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         collide;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  prio_enc_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .collide   (collide),
    .busy      (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one active edge, then settle so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    en        = 1'b1;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [W-1:0] idx);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) check({tag, ".idx"}, 32'(out_idx), 32'(idx));
  endtask

  initial begin
    // Reset held with every request active: nothing may be captured.
    rst_n     = 1'b0;
    en        = 1'b1;
    req       = 8'hFF;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst.valid",   32'(out_valid), 32'd0);
      check("rst.idx",     32'(out_idx),   32'd0);
      check("rst.collide", 32'(collide),   32'd0);
      check("rst.busy",    32'(busy),      32'd0);
    end
    req   = '0;
    rst_n = 1'b1;
    step();
    check("rst.after_release_valid", 32'(out_valid), 32'd0);

    // Burst drain: one-cycle 8'hFF pulse drains 7..0 back to back.
    do_reset();
    req = 8'hFF;
    step();
    req = '0;
    expect_out("burst.7", 1'b1, 3'd7);
    check("burst.busy", 32'(busy), 32'd1);
    for (int k = 6; k >= 0; k--) begin
      step();
      expect_out($sformatf("burst.%0d", k), 1'b1, W'(k));
    end
    step();
    check("burst.end_valid", 32'(out_valid), 32'd0);
    check("burst.end_busy",  32'(busy),      32'd0);
    check("burst.end_idx",   32'(out_idx),   32'd0);

    // Stall and accumulate, then release.
    do_reset();
    out_ready = 1'b0;
    req = 8'h01;
    step();
    expect_out("stall.first", 1'b1, 3'd0);
    req = 8'h10;
    step();
    expect_out("stall.hold1", 1'b1, 3'd0);
    req = '0;
    step();
    expect_out("stall.hold2", 1'b1, 3'd0);
    check("stall.busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    step();
    expect_out("stall.second", 1'b1, 3'd4);
    step();
    check("stall.end_valid", 32'(out_valid), 32'd0);
    check("stall.end_idx",   32'(out_idx),   32'd4);

    // Reset mid-operation discards pending work at once.
    out_ready = 1'b0;
    req = 8'h0F;
    step();
    req = '0;
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.busy",  32'(busy),      32'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("midrst.stays_idle", 32'(out_valid), 32'd0);

    // Enable mask.
    do_reset();
    en  = 1'b0;
    req = 8'h80;
    step();
    check("en.masked_valid", 32'(out_valid), 32'd0);
    check("en.masked_busy",  32'(busy),      32'd0);
    en = 1'b1;
    step();
    expect_out("en.open", 1'b1, 3'd7);
    req = '0;
    step();
    check("en.end_valid", 32'(out_valid), 32'd0);

    // Collision: output occupied by index 3, req 8'h04 held two cycles.
    do_reset();
    out_ready = 1'b0;
    req = 8'h08;
    step();
    expect_out("col.occupy", 1'b1, 3'd3);
    req = 8'h04;
    step();
    check("col.first_cycle", 32'(collide), 32'd0);
    step();
    check("col.pulse", 32'(collide), 32'd1);
    expect_out("col.hold", 1'b1, 3'd3);
    req = '0;
    step();
    check("col.pulse_end", 32'(collide), 32'd0);
    out_ready = 1'b1;
    step();
    expect_out("col.idx2", 1'b1, 3'd2);
    step();
    check("col.once_valid", 32'(out_valid), 32'd0);
    check("col.once_busy",  32'(busy),      32'd0);

    // Priority mode: req 8'h82 held with out_ready high.
    do_reset();
    req = 8'h82;
    step();
    expect_out("prio.c1", 1'b1, 3'd7);
    check("prio.c1_collide", 32'(collide), 32'd0);
`ifdef PRIO_ENC_RR_EN
    step();
    expect_out("prio.c2", 1'b1, 3'd1);
    check("prio.c2_collide", 32'(collide), 32'd1);
    step();
    expect_out("prio.c3", 1'b1, 3'd7);
    check("prio.c3_collide", 32'(collide), 32'd1);
    step();
    expect_out("prio.c4", 1'b1, 3'd1);
    req = '0;
    step();
    expect_out("prio.drain", 1'b1, 3'd7);
`else
    step();
    expect_out("prio.c2", 1'b1, 3'd7);
    check("prio.c2_collide", 32'(collide), 32'd1);
    step();
    expect_out("prio.c3", 1'b1, 3'd7);
    check("prio.c3_collide", 32'(collide), 32'd1);
    step();
    expect_out("prio.c4", 1'b1, 3'd7);
    req = '0;
    step();
    expect_out("prio.drain", 1'b1, 3'd1);
`endif
    check("prio.drain_collide", 32'(collide), 32'd0);
    step();
    check("prio.end_valid", 32'(out_valid), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prio_enc_pipe.md
# prio_enc_pipe

Parametrised, registered N-input priority encoder with a pending-request store and a valid/ready output. It supersedes the fixed 8-to-3 combinational encoder in the same design. Request pulses are captured into a pending vector and emitted one index per accepted transfer, highest priority first. Selectable fixed or round-robin priority lets downstream logic service every request without losing pulses while stalled.

## Interface
- N, 8, number of request inputs (N >= 2)
- W, $clog2(N) (localparam), index width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  request enable; 0 masks req (nothing captured)
- req  input  N  request bits, bit i = request from source i, pulse or level
- out_ready  input  1  downstream accepts out_idx when high with out_valid
- out_valid  output  1  out_idx holds a valid encoded index
- out_idx  output  W  encoded index of granted source
- collide  output  1  one-cycle pulse: a request merged into an already-pending bit
- busy  output  1  combinational: |pend or out_valid

## Operation
- Internal: pend[N-1:0] pending vector; ptr[W-1:0] priority pointer.
- Candidate vector each cycle: c = pend | (en ? req : 0).
- Load condition: load = (!out_valid || out_ready) && (c != 0).
- On load:
  - out_idx <= sel, the highest-priority set bit of c.
  - out_valid <= 1.
  - pend <= c & ~onehot(sel).
- Not loading, with c != 0: pend <= c; output registers hold.
- If c == 0 and out_valid && out_ready: out_valid <= 0; out_idx holds its last value.
- Fixed priority (default): highest index wins (bit N-1 first, bit 0 last). ptr is constant N-1.
- collide <= |(en ? req & pend : 0), registered. The merged request is not serviced twice.
- Same-cycle capture and selection: if req bit k is set in the cycle k is selected, k is granted once and does not remain pending.
- No tristate outputs. en=0 only blocks capture; pending requests still drain.

## Timing
- Reset (async assert, sync release by system): pend=0, out_valid=0, out_idx=0, collide=0, ptr=N-1.
- Latency: req sampled at edge t appears on out_idx/out_valid after edge t when load is true, i.e. 1 cycle.
- Throughput: one index per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_idx is stable. New requests accumulate in pend.
- collide asserts the cycle after the merging request, for one cycle per occurrence.
- Reset mid-operation discards all pending requests and any unaccepted out_idx immediately.
- N not a power of 2: indices >= N are never produced.

## Configuration
- Macro PRIO_ENC_RR_EN.
- Defined: round-robin priority.
  - Search starts at ptr and descends, wrapping from 0 to N-1.
  - On each load of index k, ptr <= (k == 0) ? N-1 : k-1, so k becomes lowest priority.
- Undefined: fixed MSB-first priority. ptr logic is removed.
- Both builds keep identical ports and reset values.

## Test plan
- Reset: rst_n=0 with req=8'hFF, en=1 -> out_valid=0, out_idx=0, collide=0, busy=0 throughout. No capture occurs.
- Burst drain: N=8, out_ready=1, single-cycle req=8'hFF -> out_idx = 7,6,5,4,3,2,1,0 on 8 consecutive cycles, then out_valid=0. Expected in both builds.
- Stall/accumulate: out_ready=0, pulses req=8'h01 then 8'h10 -> out_idx=0 held stable. Raise out_ready -> transfers 0 then 4, then out_valid=0.
- Enable mask: en=0 with req=8'h80 -> no out_valid. en=1 next cycle with same req -> out_idx=7 after one edge.
- Collision: out_ready=0, req=8'h04 for 2 cycles -> collide pulses once. After release, index 2 is emitted exactly once.
- Priority mode: req=8'h82 held, out_ready=1 -> fixed build emits 7 every cycle with collide pulsing. PRIO_ENC_RR_EN build alternates 7,1,7,1.
